// File: rtl/hcp_expand.sv
// rtl/hcp_expand.sv - Picnic challenge parser: expands a digest into Lc (distinct rounds) and Lp (parties)
module hcp_expand #(
    parameter int T   = 8,
    parameter int TAU = 4,
    parameter int NP  = 16,
    parameter int HW  = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [HW-1:0]                 seed,
    output logic                          busy,
    output logic                          done,
    output logic [TAU*$clog2(T)-1:0]      lc,
    output logic [TAU*$clog2(NP)-1:0]     lp,
    output logic                          hash_req,
    output logic [HW-1:0]                 hash_in,
    input  logic                          hash_ack,
    input  logic [HW-1:0]                 hash_out,
    output logic [7:0]                    rehash_cnt
);
    localparam int CW = $clog2(T);
    localparam int PW = $clog2(NP);
    localparam int KW = $clog2(HW + 1);
    localparam int NW = $clog2(TAU + 1);
    localparam logic [KW-1:0] KC_V  = KW'(HW / CW);
    localparam logic [KW-1:0] KP_V  = KW'(HW / PW);
    localparam logic [NW-1:0] TAU_V = NW'(TAU);
    localparam logic [CW:0]   T_V   = (CW + 1)'(T);
    localparam logic [PW:0]   NP_V  = (PW + 1)'(NP);

    typedef enum logic [2:0] {
        S_IDLE, S_PARSE_C, S_PARSE_P, S_HREQ, S_HWAIT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                tgt_p_q, tgt_p_d;
    logic [HW-1:0]       d_q, d_d, s_q, s_d;
    logic [KW-1:0]       k_q, k_d, k_inc;
    logic [NW-1:0]       n_q, n_d, n_inc;
    logic [TAU*CW-1:0]   lc_acc_q, lc_acc_d, lc_q, lc_d;
    logic [TAU*PW-1:0]   lp_acc_q, lp_acc_d, lp_q, lp_d;
    logic                hash_req_q, hash_req_d;
    logic [HW-1:0]       hash_in_q, hash_in_d;
    logic [7:0]          rcnt_q, rcnt_d;
    logic [CW-1:0]       c_chunk;
    logic [PW-1:0]       p_chunk;
    logic                c_dup, c_ok, p_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tgt_p_q    <= 1'b0;
            d_q        <= '0;
            s_q        <= '0;
            k_q        <= '0;
            n_q        <= '0;
            lc_acc_q   <= '0;
            lp_acc_q   <= '0;
            lc_q       <= '0;
            lp_q       <= '0;
            hash_req_q <= 1'b0;
            hash_in_q  <= '0;
            rcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            tgt_p_q    <= tgt_p_d;
            d_q        <= d_d;
            s_q        <= s_d;
            k_q        <= k_d;
            n_q        <= n_d;
            lc_acc_q   <= lc_acc_d;
            lp_acc_q   <= lp_acc_d;
            lc_q       <= lc_d;
            lp_q       <= lp_d;
            hash_req_q <= hash_req_d;
            hash_in_q  <= hash_in_d;
            rcnt_q     <= rcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tgt_p_d    = tgt_p_q;
        d_d        = d_q;
        s_d        = s_q;
        k_d        = k_q;
        n_d        = n_q;
        lc_acc_d   = lc_acc_q;
        lp_acc_d   = lp_acc_q;
        lc_d       = lc_q;
        lp_d       = lp_q;
        hash_req_d = hash_req_q;
        hash_in_d  = hash_in_q;
        rcnt_d     = rcnt_q;
        k_inc      = k_q + 1'b1;
        n_inc      = n_q + 1'b1;
        c_chunk    = s_q[HW-1 -: CW];
        p_chunk    = s_q[HW-1 -: PW];
        // Accepted entries are shifted in at the LSB, so entry j (newest first) sits at j*CW.
        c_dup      = 1'b0;
        for (int j = 0; j < TAU; j++) begin
            if (NW'(j) < n_q && lc_acc_q[j*CW +: CW] == c_chunk) begin
                c_dup = 1'b1;
            end
        end
        c_ok = ({1'b0, c_chunk} < T_V) && !c_dup;
        p_ok = {1'b0, p_chunk} < NP_V;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    d_d      = seed;
                    s_d      = seed;
                    k_d      = '0;
                    n_d      = '0;
                    rcnt_d   = '0;
                    lc_acc_d = '0;
                    lp_acc_d = '0;
                    state_d  = S_PARSE_C;
                end
            end
            S_PARSE_C: begin
                s_d = s_q << CW;
                k_d = k_inc;
                if (c_ok) begin
                    lc_acc_d = (lc_acc_q << CW) | (TAU*CW)'(c_chunk);
                    n_d      = n_inc;
                end
                // Completion wins over exhaustion on the last chunk.
                if (c_ok && n_inc == TAU_V) begin
                    n_d     = '0;
                    tgt_p_d = 1'b1;
                    state_d = S_HREQ;
                end else if (k_inc == KC_V) begin
                    tgt_p_d = 1'b0;
                    state_d = S_HREQ;
                end
            end
            S_PARSE_P: begin
                s_d = s_q << PW;
                k_d = k_inc;
                if (p_ok) begin
                    lp_acc_d = (lp_acc_q << PW) | (TAU*PW)'(p_chunk);
                    n_d      = n_inc;
                end
                if (p_ok && n_inc == TAU_V) begin
                    lc_d    = lc_acc_q;
                    lp_d    = lp_acc_d;
                    state_d = S_DONE;
                end else if (k_inc == KP_V) begin
                    tgt_p_d = 1'b1;
                    state_d = S_HREQ;
                end
            end
            S_HREQ: begin
                hash_req_d = 1'b1;
                hash_in_d  = d_q;
                rcnt_d     = (rcnt_q == 8'hFF) ? rcnt_q : rcnt_q + 8'd1;
                state_d    = S_HWAIT;
            end
            S_HWAIT: begin
                if (hash_ack) begin
                    hash_req_d = 1'b0;
                    d_d        = hash_out;
                    s_d        = hash_out;
                    k_d        = '0;
                    state_d    = tgt_p_q ? S_PARSE_P : S_PARSE_C;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign lc         = lc_q;
    assign lp         = lp_q;
    assign hash_req   = hash_req_q;
    assign hash_in    = hash_in_q;
    assign rehash_cnt = rcnt_q;
endmodule

// File: tb/tb_hcp_expand.sv
// tb/tb_hcp_expand.sv - scoreboard bench for hcp_expand (default and NP=12 instances)
module tb_hcp_expand;
    localparam int HW = 256;

    typedef struct {
        logic [11:0] lc;
        logic [15:0] lp;
        logic [7:0]  rc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, start2;
    logic [HW-1:0] seed;
    logic          busy, done, hash_req, hash_ack;
    logic [11:0]   lc;
    logic [15:0]   lp;
    logic [HW-1:0] hash_in, hash_out;
    logic [7:0]    rehash_cnt;
    logic          busy2, done2, req2, ack2;
    logic [11:0]   lc2;
    logic [15:0]   lp2;
    logic [HW-1:0] hin2, hout2;
    logic [7:0]    rc2;

    exp_t          exp_q[$];
    exp_t          exp2_q[$];
    logic [HW-1:0] hin_q[$];
    logic [HW-1:0] rsp_q[$];
    int            ack_delay = 3;
    int            pass_cnt = 0;
    int            chk_cnt = 0;

    hcp_expand dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .busy(busy), .done(done), .lc(lc), .lp(lp),
        .hash_req(hash_req), .hash_in(hash_in), .hash_ack(hash_ack),
        .hash_out(hash_out), .rehash_cnt(rehash_cnt)
    );

    hcp_expand #(.NP(12)) dut12 (
        .clk(clk), .reset(reset), .start(start2), .seed(seed),
        .busy(busy2), .done(done2), .lc(lc2), .lp(lp2),
        .hash_req(req2), .hash_in(hin2), .hash_ack(ack2),
        .hash_out(hout2), .rehash_cnt(rc2)
    );

    task automatic chk(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Hash model for the default instance; gives up on the request if reset hits while waiting.
    initial begin
        int dly;
        bit aborted;
        hash_ack = 1'b0;
        hash_out = '0;
        forever begin
            @(negedge clk);
            if (reset && hash_req) begin
                if (hin_q.size() == 0) chk("hash_req_unexpected", hash_req, 0);
                else chk("hash_in", hash_in, hin_q.pop_front());
                dly = ack_delay;
                aborted = 1'b0;
                for (int i = 1; i < dly; i++) begin
                    @(negedge clk);
                    if (!reset) aborted = 1'b1;
                end
                if (!aborted) begin
                    hash_out = (rsp_q.size() != 0) ? rsp_q.pop_front() : '0;
                    hash_ack = 1'b1;
                    @(negedge clk);
                    hash_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        ack2  = 1'b0;
        hout2 = '0;
        forever begin
            @(negedge clk);
            if (reset && req2) begin
                chk("np12_hash_in", hin2, {12'h29C, 244'h0});
                repeat (2) @(negedge clk);
                hout2 = {24'hFCB007, 232'h0};
                ack2  = 1'b1;
                @(negedge clk);
                ack2  = 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) chk("done_unexpected", done, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("lc", lc, e.lc);
                    chk("lp", lp, e.lp);
                    chk("rehash_cnt", rehash_cnt, e.rc);
                    chk("busy_at_done", busy, 0);
                end
                @(negedge clk);
                chk("done_one_cycle", done, 0);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done2) begin
                if (exp2_q.size() == 0) chk("np12_done_unexpected", done2, 0);
                else begin
                    e = exp2_q.pop_front();
                    chk("np12_lc", lc2, e.lc);
                    chk("np12_lp", lp2, e.lp);
                    chk("np12_rehash_cnt", rc2, e.rc);
                end
            end
        end
    end

    task automatic run(input logic [HW-1:0] sd, input int req_e, input int done_e, input bit mid);
        int cnt;
        @(negedge clk);
        seed  = sd;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
        cnt = 0;
        while (!hash_req && cnt < 400) begin
            @(posedge clk);
            #1 cnt++;
            if (mid && cnt == 2) begin
                start = 1'b1;
                seed  = '1;
            end else start = 1'b0;
        end
        chk("req_latency", cnt, req_e);
        while (!done && cnt < 400) begin
            @(posedge clk);
            #1 cnt++;
        end
        chk("done_latency", cnt, done_e);
        @(negedge clk);
    endtask

    initial begin
        logic [HW-1:0] sdef, sdup, s5, hdef, r1;
        exp_t e;
        int cnt;
        sdef = {12'h29C, 244'h0};
        sdup = {18'b001_001_010_001_011_100, 238'h0};
        hdef = {16'hA5C3, 240'h0};
        r1   = {9'b001_010_011, 247'h0};
        s5   = '0;
        for (int i = 0; i < 85; i++) s5[HW-1-3*i -: 3] = 3'b101;

        reset = 1'b0; start = 1'b0; start2 = 1'b0; seed = '0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hash_req", hash_req, 0);
        chk("rst_hash_in", hash_in, 0);
        chk("rst_lc", lc, 0);
        chk("rst_lp", lp, 0);
        chk("rst_rehash_cnt", rehash_cnt, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // defaults
        e = '{12'h29C, 16'hA5C3, 8'd1}; exp_q.push_back(e);
        hin_q.push_back(sdef); rsp_q.push_back(hdef);
        run(sdef, 5, 12, 1'b0);

        // duplicate rejection: six Lc chunk cycles
        exp_q.push_back(e);
        hin_q.push_back(sdup); rsp_q.push_back(hdef);
        run(sdup, 7, 14, 1'b0);

        // exhaustion after 85 chunks, then C re-hash
        e = '{12'hA53, 16'hA5C3, 8'd2}; exp_q.push_back(e);
        hin_q.push_back(s5); rsp_q.push_back(r1);
        hin_q.push_back(r1); rsp_q.push_back(hdef);
        run(s5, 86, 100, 1'b0);

        // start pulsed while busy is ignored
        e = '{12'h29C, 16'hA5C3, 8'd1}; exp_q.push_back(e);
        hin_q.push_back(sdef); rsp_q.push_back(hdef);
        run(sdef, 5, 12, 1'b1);

        // stretched handshake aborted by reset in the fifth HWAIT cycle
        ack_delay = 10;
        hin_q.push_back(sdef);
        @(negedge clk);
        seed = sdef; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cnt = 0;
        while (!hash_req && cnt < 400) begin
            @(posedge clk);
            #1 cnt++;
        end
        chk("abort_req_latency", cnt, 5);
        repeat (4) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("abort_hash_req", hash_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_lc", lc, 0);
        chk("abort_lp", lp, 0);
        chk("abort_rehash_cnt", rehash_cnt, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        ack_delay = 3;
        repeat (4) @(negedge clk);
        e = '{12'h29C, 16'hA5C3, 8'd1}; exp_q.push_back(e);
        hin_q.push_back(sdef); rsp_q.push_back(hdef);
        run(sdef, 5, 12, 1'b0);

        // NP=12 instance: 15 and 12 rejected
        e = '{12'h29C, 16'hB007, 8'd1}; exp2_q.push_back(e);
        @(negedge clk);
        seed = sdef; start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        cnt = 0;
        while (!done2 && cnt < 400) begin
            @(posedge clk);
            #1 cnt++;
        end
        chk("np12_done_latency", cnt, 14);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size() + exp2_q.size() + hin_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/hcp_expand.md
Name: hcp_expand

Overview:
- Parametrised hash-challenge parser for the Picnic verifier.
- Expands a seed digest into two challenge lists:
  - Lc: TAU distinct round indices, each < T.
  - Lp: TAU party indices, each < NP.
- Uses rejection sampling on fixed-width MSB-first bit chunks. When a digest runs out of chunks, the block re-hashes it through an external hash-engine handshake.
- Sits between the challenge-hash stage and the per-round verify control; replaces the fixed 4-of-8/16 parser.

Parameters:
- T, 8, number of rounds; Lc values in [0, T-1]; T >= TAU, T >= 2.
- TAU, 4, number of entries in each list.
- NP, 16, number of parties; Lp values in [0, NP-1]; need not be a power of two.
- HW, 256, digest width in bits.
- CW, clog2(T), Lc chunk width (derived localparam).
- PW, clog2(NP), Lp chunk width (derived localparam).

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request; sampled only in IDLE.
- seed, input, HW, initial digest; sampled on accepted start.
- busy, output, 1, high from the cycle after accepted start until DONE.
- done, output, 1, one-cycle pulse when lc/lp are valid.
- lc, output, TAU*CW, Lc list; entry 0 in the MSBs, in acceptance order.
- lp, output, TAU*PW, Lp list; entry 0 in the MSBs.
- hash_req, output, 1, request hash of hash_in.
- hash_in, output, HW, digest to re-hash; stable while hash_req is high.
- hash_ack, input, 1, one-cycle response strobe.
- hash_out, input, HW, new digest; valid when hash_ack is high.
- rehash_cnt, output, 8, number of hash requests in the current run; saturates at 255.

Behaviour:
- Reset (asynchronous, active-low) clears everything: state=IDLE, busy=0, done=0, hash_req=0, hash_in=0, lc=0, lp=0, rehash_cnt=0.
- Reset mid-operation aborts immediately. A hash_ack arriving after reset release while in IDLE is ignored.
- State machine:
  - IDLE: start=1 → load digest register D=seed and shift register S=seed; clear chunk counter k, slot counter n, rehash_cnt → PARSE_C. start is ignored in every other state.
  - PARSE_C: one CW-bit chunk per cycle, taken from S[HW-1 -: CW]; then S<<=CW, k++.
    - Accept if value < T and not equal to any of the n already-accepted Lc entries. Accepted value goes to slot n; n++.
    - When n reaches TAU: n=0 → HREQ (target P).
    - Else if k == floor(HW/CW) with no completion: → HREQ (target C).
  - PARSE_P: same as PARSE_C with PW-bit chunks.
    - Accept if value < NP; duplicates are allowed.
    - Exhaustion limit is floor(HW/PW).
    - When n reaches TAU → DONE.
  - HREQ: hash_req=1, hash_in=D (the unshifted current digest), rehash_cnt++ → HWAIT.
  - HWAIT: hold hash_req and hash_in until hash_ack. On ack: hash_req=0, D=S=hash_out, k=0 → target parse state.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Lp parsing always starts from a fresh digest H(D), never from leftover Lc bits.
- Remainder bits (HW mod chunk width) are discarded.
- A chunk that completes the list on the last available position goes to HREQ (target P) or DONE, never to a C-rehash.
- lc/lp are updated only in DONE and hold their value until the next DONE. Intermediate slots are internal registers.
- Latency with no re-hashes beyond the mandatory one: 1 (IDLE) + Lc chunk cycles + 2 + hash latency + Lp chunk cycles + 1.
- hash_ack received outside HWAIT is ignored.

Test Plan:
- Defaults (CW=3, PW=4).
  - Stimulus: seed top 12 bits = 001_010_011_100; hash model returns a digest with top 16 bits 0xA5C3, ack 3 cycles after req.
  - Required: lc={1,2,3,4}, lp={0xA,0x5,0xC,0x3}, rehash_cnt=1, one done pulse, hash_in==seed during the request.
- Duplicate rejection.
  - Stimulus: seed chunks 1,1,2,1,3,4.
  - Required: lc={1,2,3,4} after exactly 6 PARSE_C cycles.
- Exhaustion.
  - Stimulus: seed of all-5 chunks (3'b101 repeated).
  - Required: 5 accepted; hash_req rises after chunk 85 with hash_in=seed. Model returns top chunks 1,2,3 → lc={5,1,2,3}; rehash_cnt=2 at done.
- NP=12.
  - Stimulus: P-digest top chunks 15,12,11,0,0,7.
  - Required: 15 and 12 rejected; lp={11,0,0,7}.
- Handshake stretch and abort.
  - Stimulus: hold hash_ack low for 10 cycles; assert reset in cycle 5 of HWAIT.
  - Required: hash_req/busy/done drop asynchronously to 0, lc/lp=0. A subsequent start with the defaults seed completes correctly.
- Start while busy.
  - Stimulus: pulse start mid-PARSE_C with a different seed.
  - Required: ignored; results match the original seed.
